sync_fifo: RTL

//  Single-clock parametrised FIFO: storage, pointer control, occupancy count and status flags.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/sync_fifo_ram.sv | 25 ++
 rtl/sync_fifo.sv | 94 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions used by the single-clock and async FIFO families.
//   fifo_mode_e : read-port behaviour, registered (MODE_STD) or first-word-fall-through (MODE_FWFT)
package fifo_pkg;

  typedef enum logic {
    MODE_STD  = 1'b0,
    MODE_FWFT = 1'b1
  } fifo_mode_e;

  // Occupancy after one cycle, given which side was accepted.
  function automatic logic [31:0] next_count(input logic [31:0] cnt,
                                             input logic wr_acc,
                                             input logic rd_acc);
    logic [31:0] nxt;
    nxt = cnt;
    if (wr_acc && !rd_acc) nxt = cnt + 32'd1;
    if (rd_acc && !wr_acc) nxt = cnt - 32'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// FIFO storage array: DEPTH x DATA_WIDTH words.
//   clk   : write clock
//   we    : write enable, waddr/wdata written on posedge clk
//   raddr : asynchronous read address, rdata follows combinationally
module sync_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, full/empty, almost flags,
// overflow/underflow pulses and selectable registered or FWFT read port.
//   clk, rst          : clock, synchronous active-high reset
//   wr_en, data_in    : write request and data (dropped while full)
//   rd_en             : read request (FWFT: acknowledge of head word)
//   data_out          : read data
//   full, empty       : occupancy == DEPTH / == 0
//   almost_full/empty : count >= AFULL_THRESH / count <= AEMPTY_THRESH
//   count             : occupancy 0..DEPTH
//   overflow/underflow: one-cycle pulse after a rejected write / read
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int         DATA_WIDTH    = 8,
  parameter int         ADDR_WIDTH    = 6,
  parameter fifo_mode_e MODE          = MODE_STD,
  parameter int         AFULL_THRESH  = (1 << ADDR_WIDTH) - 4,
  parameter int         AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  generate
    if (!(AEMPTY_THRESH >= 0 && AEMPTY_THRESH < AFULL_THRESH && AFULL_THRESH <= DEPTH)) begin : g_thresh_bad
      $error("sync_fifo: thresholds must satisfy 0 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
    end
  endgenerate

  // Pointers carry one extra wrap bit above the memory address.
  logic [CW-1:0]         wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] rd_data_p1;
  logic                  wr_acc, rd_acc;
  logic [31:0]           count_nxt;

  assign wr_acc    = wr_en & ~full;
  assign rd_acc    = rd_en & ~empty;
  assign count_nxt = next_count(32'(count), wr_acc, rd_acc);

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc & ~rst),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (rdata)
  );

  // Stage p1: pointers, occupancy, status pulses and registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      rd_data_p1 <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + CW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + CW'(1);
      count     <= count_nxt[CW-1:0];
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
      if (MODE == MODE_STD && rd_acc) rd_data_p1 <= rdata;
    end
  end

  // Flags decode only registered count, never the request inputs.
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AFULL_THRESH));
  assign almost_empty = (count <= CW'(AEMPTY_THRESH));

  assign data_out = (MODE == MODE_FWFT) ? rdata : rd_data_p1;

endmodule
